// File: rtl/reaction_timer_core.sv
`default_nettype none
// ============================================================================
// Module   : reaction_timer_core
// Purpose  : N-player reaction-timer engine. Random pre-start delay, 1 ms
//            timing in BCD, false-start detection, tie capture, timeout and
//            a best-time record. The ms tick is derived from the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module reaction_timer_core #(
  parameter int PLAYERS     = 2,
  parameter int CLKS_PER_MS = 50000,
  parameter int LFSR_W      = 13,
  parameter int RAND_BITS   = 10,
  parameter int MIN_WAIT_MS = 400,
  parameter int HOLD_MS     = 2000
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PLAYERS-1:0] hit,
  output logic               led,
  output logic [2:0]         state_out,
  output logic [15:0]        time_bcd,
  output logic [15:0]        best_bcd,
  output logic [PLAYERS-1:0] winner,
  output logic [PLAYERS-1:0] false_start,
  output logic               timeout,
  output logic               done
);

  // State encoding is visible on state_out, so the codes are fixed.
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_ARM   = 3'b010;
  localparam logic [2:0] S_GO    = 3'b100;
  localparam logic [2:0] S_HOLD  = 3'b110;
  localparam logic [2:0] S_FAULT = 3'b001;

  // The ms counter must span both the longest random wait and the hold time.
  localparam int WAIT_MAX = MIN_WAIT_MS + (1 << RAND_BITS) - 1;
  localparam int CNT_MAX  = (WAIT_MAX > HOLD_MS) ? WAIT_MAX : HOLD_MS;
  localparam int MS_W     = $clog2(CNT_MAX + 1);
  localparam int PS_W     = $clog2(CLKS_PER_MS);

  localparam logic [PS_W-1:0] C_PS_LAST  = PS_W'(CLKS_PER_MS - 1);
  localparam logic [MS_W-1:0] C_HOLD_MS  = MS_W'(HOLD_MS);
  localparam logic [MS_W-1:0] C_MIN_WAIT = MS_W'(MIN_WAIT_MS);
  localparam logic [15:0]     C_BCD_MAX  = 16'h9999;

  logic [2:0]         r_state;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [PS_W-1:0]    r_presc;
  logic [MS_W-1:0]    r_ms;
  logic [MS_W-1:0]    r_wait;
  logic               r_led;
  logic [15:0]        r_time;
  logic [15:0]        r_best;
  logic [PLAYERS-1:0] r_winner;
  logic [PLAYERS-1:0] r_false;
  logic               r_timeout;
  logic               r_done;

  logic [2:0]         w_next;
  logic               w_enter;
  logic               w_tick;
  logic               w_hit_any;
  logic [MS_W-1:0]    w_ms_inc;
  logic               w_lfsr_fb;
  logic [15:0]        w_bcd_inc;
  logic               w_cy;

  assign w_tick    = (r_presc == C_PS_LAST);
  assign w_hit_any = |hit;
  assign w_ms_inc  = r_ms + MS_W'(1);
  // x^13 + x^12 + x^11 + x^8 + 1, shifted left, feedback into bit 0.
  assign w_lfsr_fb = r_lfsr[12] ^ r_lfsr[11] ^ r_lfsr[10] ^ r_lfsr[7];
  assign w_enter   = (w_next != r_state);

  // Free-running random source; seeded with 1 so it never locks up at 0.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_lfsr <= LFSR_W'(1);
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
    end
  end

  // One-count BCD increment with a decimal carry ripple from the 1 ms digit up.
  always_comb begin
    w_bcd_inc = r_time;
    w_cy      = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (w_cy) begin
        if (r_time[d*4 +: 4] == 4'd9) begin
          w_bcd_inc[d*4 +: 4] = 4'd0;
        end else begin
          w_bcd_inc[d*4 +: 4] = r_time[d*4 +: 4] + 4'd1;
          w_cy                = 1'b0;
        end
      end
    end
  end

  // Next-state selection; a hit always wins over a coincident tick event.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ARM;
      end
      S_ARM: begin
        if (w_hit_any)                             w_next = S_FAULT;
        else if (w_tick && (w_ms_inc == r_wait))   w_next = S_GO;
      end
      S_GO: begin
        if (w_hit_any)                             w_next = S_HOLD;
        else if (w_tick && (r_time == C_BCD_MAX))  w_next = S_HOLD;
      end
      S_HOLD, S_FAULT: begin
        if (w_tick && (w_ms_inc == C_HOLD_MS))     w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, timebase and result registers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_ms      <= '0;
      r_wait    <= '0;
      r_led     <= 1'b0;
      r_time    <= 16'h0000;
      r_best    <= C_BCD_MAX;
      r_winner  <= '0;
      r_false   <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_led   <= (w_next == S_GO);
      r_done  <= ((r_state == S_HOLD) || (r_state == S_FAULT)) && (w_next == S_IDLE);

      // Prescaler restarts on every state entry so each state gets whole ms.
      if (w_enter || w_tick) r_presc <= '0;
      else                   r_presc <= r_presc + PS_W'(1);

      // ms counter shares the same restart so ARM and HOLD count from zero.
      if (w_enter)     r_ms <= '0;
      else if (w_tick) r_ms <= w_ms_inc;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wait    <= C_MIN_WAIT + MS_W'(r_lfsr[RAND_BITS-1:0]);
            r_winner  <= '0;
            r_false   <= '0;
            r_timeout <= 1'b0;
          end
        end
        S_ARM: begin
          if (w_hit_any)          r_false <= hit;
          else if (w_next == S_GO) r_time <= 16'h0000;
        end
        S_GO: begin
          if (w_hit_any) begin
            r_winner <= hit;
            // Digit vectors compare correctly as plain binary.
            if (r_time < r_best) r_best <= r_time;
          end else if (w_tick) begin
            if (r_time == C_BCD_MAX) r_timeout <= 1'b1;
            else                     r_time    <= w_bcd_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state_out   = r_state;
  assign led         = r_led;
  assign time_bcd    = r_time;
  assign best_bcd    = r_best;
  assign winner      = r_winner;
  assign false_start = r_false;
  assign timeout     = r_timeout;
  assign done        = r_done;

endmodule
`default_nettype wire
